// File: rtl/crc7_cmd_sequencer.sv
// SD-card command framer: latches a command, runs the external CRC-7 engine,
// then shifts the 48-bit frame MSB-first onto the CMD line at the bit_tick rate.
module crc7_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TMO_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic [39:0] crc_data,
    output logic        crc_start,
    input  logic        crc_done,
    input  logic [6:0]  crc_in,
    input  logic        bit_tick,
    output logic        sd_cmd_out,
    output logic        sd_cmd_oe,
    output logic        busy,
    output logic        frame_done,
    output logic        err_timeout
);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, SHIFT, DONE} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [47:0]       shift_reg;
    logic [5:0]        bit_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [47:0]       frame_word;

    // crc_data already carries {2'b01, index, arg}, i.e. start bit, direction bit and payload.
    assign frame_word = {crc_data, crc_in, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            crc_start   <= 1'b0;
            crc_data    <= '0;
            sd_cmd_out  <= 1'b1;
            sd_cmd_oe   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
        end else begin
            crc_start   <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        crc_data  <= {2'b01, cmd_index, cmd_arg};
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        crc_start <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // crc_done is checked before the timeout so a late done still wins.
                    if (crc_done) begin
                        shift_reg  <= frame_word;
                        sd_cmd_out <= frame_word[47];
                        sd_cmd_oe  <= 1'b1;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        cmd_ready   <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_tick) begin
                        shift_reg <= {shift_reg[46:0], 1'b0};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 6'd47) begin
                            sd_cmd_out <= 1'b1;
                            sd_cmd_oe  <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            sd_cmd_out <= shift_reg[46];
                        end
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/crc7_cmd_sequencer.md
Name: crc7_cmd_sequencer

Overview:
- Sequences the crc_7 engine to build and transmit SD-card command frames on the SoC's J1 side.
- Accepts a command index and argument through a valid/ready handshake.
- Loads and starts the external CRC-7 engine, waits for its done flag, and captures the CRC.
- Serialises the 48-bit frame MSB-first onto the SD CMD line, paced by an external bit-rate tick.

Parameters:
- TIMEOUT_CYCLES, 64, maximum clk cycles to wait for crc_done after crc_start before aborting.
- TMO_W, 7, width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; a command is accepted on the cycle where cmd_valid && cmd_ready.
- cmd_index  input  6  SD command index.
- cmd_arg  input  32  SD command argument.
- crc_data  output  40  message to the CRC engine, {2'b01, index, arg}; held stable from LOAD until the next accept.
- crc_start  output  1  one-cycle start pulse to the CRC engine.
- crc_done  input  1  CRC engine done flag.
- crc_in  input  7  CRC engine result; valid while crc_done is high.
- bit_tick  input  1  one-cycle bit-rate enable.
- sd_cmd_out  output  1  serial CMD line data; idles at 1.
- sd_cmd_oe  output  1  CMD line output enable.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse when a frame completes.
- err_timeout  output  1  one-cycle pulse when the CRC wait is aborted.

Behaviour:
- States: IDLE, LOAD, WAIT, SHIFT, DONE.
- Reset values: state=IDLE, cmd_ready=1, crc_start=0, crc_data=0, sd_cmd_out=1, sd_cmd_oe=0, busy=0, frame_done=0, err_timeout=0. Internal counters and the shift register are cleared.
- IDLE: on accept, latch index and arg, drive crc_data, go to LOAD. cmd_ready drops the following cycle.
- LOAD: assert crc_start for exactly 1 cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - crc_done is sampled only here, so a crc_done high during the LOAD cycle is ignored.
  - On crc_done=1: build shift_reg = {1'b0, 1'b1, index, arg, crc_in, 1'b1} (48 bits), clear bit_cnt, go to SHIFT.
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without crc_done: pulse err_timeout, go to IDLE, transmit nothing.
  - crc_done arriving on the final count cycle wins over the timeout.
- SHIFT:
  - sd_cmd_oe=1 and sd_cmd_out=shift_reg[47]; bit 47 is driven in the first SHIFT cycle.
  - On each bit_tick: shift left by 1 and increment bit_cnt.
  - On the bit_tick where bit_cnt==47, go to DONE; the end bit has then been held for a full tick period.
  - A bit_tick on the cycle of entry into SHIFT counts as the first bit's tick.
  - Without bit_tick, state and bit are held indefinitely.
- DONE: frame_done=1 for 1 cycle, sd_cmd_oe=0, sd_cmd_out=1, go to IDLE.
- Latency:
  - Accept to crc_start = 1 cycle.
  - crc_done to first bit driven = 1 cycle.
  - Frame duration = 48 bit_tick periods.
- Ignored inputs:
  - cmd_valid while busy: not accepted; no queueing.
  - Changes on cmd_index/cmd_arg after accept: no effect.
- crc_done or bit_tick in IDLE or DONE: ignored.
- rst in any state: back to IDLE with the reset values on the next edge; a frame in progress is truncated, CMD goes to 1 with oe=0, and no frame_done or err_timeout pulse is produced.

Test Plan:
- CMD0, arg 0x00000000; CRC model returns crc_in=0x4A after 5 cycles -> crc_data=0x4000000000, one crc_start pulse, serial frame 0x400000000095 MSB-first, then one frame_done pulse.
- CMD8, arg 0x000001AA; crc_in=0x43; bit_tick every 4 clk -> frame 0x48000001AA87, sd_cmd_oe high for exactly 192 clk, busy low after DONE.
- CRC model never asserts done (TIMEOUT_CYCLES=64) -> err_timeout pulses once 64 cycles after crc_start, sd_cmd_oe never rises, cmd_ready=1 the next cycle.
- cmd_valid held high across a frame with a second command, CMD17 arg 0x00001000 -> second accept occurs only in IDLE after frame_done; the first frame stays uncorrupted.
- rst asserted at bit 20 of SHIFT -> next cycle state IDLE, sd_cmd_out=1, sd_cmd_oe=0, no frame_done; a new command then transmits correctly.
- bit_tick gapped irregularly (gaps of 0-10 clk) and crc_done asserted during LOAD -> the early done is ignored and the frame is still bit-exact.
